sram_fifo_ctrl: RTL and testbench
=================================

# sram_fifo_ctrl

Sequencing controller for the BRAM-backed synchronous FIFO macro (512 x DATA_WIDTH, 18Kb, DO_REG=0) behind the `fifo_v3` SRAM variant. It runs the macro's reset and recovery sequence and implements flush as a macro reset. It gates RDEN/WREN so RDERR/WRERR can never fire in correct operation. It converts the macro's one-cycle read latency into a first-word-fall-through valid/ready interface for the core-side producer and consumer.

## Interface
- DATA_WIDTH, 32: payload width
- DEPTH, 512: macro capacity in words
- RST_HOLD, 5: cycles mac_rst_o is held high
- RST_RECOVER, 4: idle cycles after mac_rst_o falls before enables may assert
- USAGE_W, $clog2(DEPTH+3): usage counter width (derived; not to be overridden)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- flush_i  in  1  discard all contents; re-runs the macro reset sequence
- in_valid_i / in_ready_o / in_data_i  in/out/in  1/1/DATA_WIDTH  producer handshake
- out_valid_o / out_ready_i / out_data_o  out/in/out  1/1/DATA_WIDTH  consumer handshake
- mac_rst_o  out  1  macro RST (active high)
- mac_wren_o, mac_di_o  out  1, DATA_WIDTH  macro write enable and data
- mac_rden_o  out  1  macro read enable
- mac_do_i  in  DATA_WIDTH  macro read data, valid one cycle after mac_rden_o
- mac_empty_i, mac_full_i, mac_rderr_i, mac_wrerr_i  in  1 each  macro flags
- init_done_o  out  1  high in RUN
- usage_o  out  USAGE_W  words held (macro + in-flight + output stage)
- err_o  out  1  sticky; macro reported RDERR or WRERR

## Operation
- FSM: HOLD -> WAIT -> RUN.
  - HOLD: mac_rst_o=1 for RST_HOLD cycles.
  - WAIT: mac_rst_o=0 and all enables 0 for RST_RECOVER cycles.
  - RUN: normal operation.
- flush_i in any state: next state is HOLD with the hold counter reloaded. mem_cnt, the output stage, the in-flight flag and err_o are cleared.
- Outside RUN: in_ready_o=0, out_valid_o=0, mac_wren_o=0, mac_rden_o=0.
- Write path:
  - in_ready_o = RUN & !flush_i & !mac_full_i & (mem_cnt < DEPTH).
  - mac_wren_o = in_valid_i & in_ready_o, combinational; mac_di_o = in_data_i.
- Read path:
  - mac_rden_o = RUN & !flush_i & !mac_empty_i & (mem_cnt != 0) & (ob_cnt + inflight - pop < 2), where pop = out_valid_o & out_ready_i.
  - The out_ready_i -> mac_rden_o combinational path is intentional.
  - The cycle after rden, mac_do_i is captured into the 2-entry output stage.
- mem_cnt (words in the macro): +1 on wren, -1 on rden; both in the same cycle leave it unchanged.
- usage_o = mem_cnt + inflight + ob_cnt.
- out_valid_o = ob_cnt != 0; out_data_o = head entry.
- A simultaneous pop and capture keeps ob_cnt constant and preserves order.
- err_o sets when mac_rderr_i | mac_wrerr_i is seen in RUN. It clears only on reset or flush.

## Timing
- rst_ni=0: state HOLD, counter=RST_HOLD, mac_rst_o=1, every other output 0, usage_o=0.
- After rst_ni rises:
  - mac_rst_o stays high for RST_HOLD cycles, then low for RST_RECOVER cycles.
  - init_done_o and in_ready_o rise on cycle RST_HOLD+RST_RECOVER.
- Read latency: out_valid_o rises the cycle after mac_rden_o. Total write-to-out_valid latency is the macro EMPTY-deassert latency plus 1.
- Sustained throughput is one word per cycle in each direction when the macro is non-empty and not full.
- Full: in_ready_o drops in the same cycle mem_cnt reaches DEPTH or mac_full_i is high.
- Empty: no rden while mac_empty_i=1, even if mem_cnt != 0.
- Mid-operation reset or flush drops the in-flight read; the mac_do_i value the following cycle is ignored.

## Structure
- Package sram_fifo_ctrl_pkg holds:
  - the state enum (HOLD, WAIT, RUN)
  - the default RST_HOLD/RST_RECOVER constants
  - the USAGE_W width function
- Sub-module sram_fifo_out_stage: 2-entry register FIFO with push/pop/count. It handles capture of mac_do_i and the FWFT head.
- Macro instantiation stays outside this block.

## Test plan
- Reset release with RST_HOLD=5, RST_RECOVER=4:
  - mac_rst_o high for exactly cycles 0-4 and low from cycle 5.
  - init_done_o=1 and in_ready_o=1 at cycle 9; no enable asserts before then.
- Single word 0xA5A5_0001 written, with a macro model whose EMPTY deasserts 1 cycle after the write:
  - rden asserts 1 cycle after the write; out_valid_o rises 1 cycle later with data 0xA5A5_0001.
  - usage_o reads 1 throughout.
- Stream 1000 incrementing words with out_ready_i=1 and random producer gaps:
  - output matches in order; no RDERR/WRERR.
  - after the fill latency, throughput is 1 word per cycle.
- out_ready_i=0, push continuously:
  - after 512 macro words plus 2 in the output stage, in_ready_o=0 and usage_o=514.
  - one pop reopens in_ready_o within 2 cycles.
- flush_i for one cycle with 37 words stored and one read in flight:
  - next cycle state is HOLD and usage_o=0.
  - after the sequence, out_valid_o=0 until new data arrives; no stale word ever appears.
- Force mac_rderr_i for one cycle in RUN: err_o=1 and it stays set until flush_i, then reads 0.

Source files
------------

// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared state encoding, default sequencing constants and width helper
// for the SRAM FIFO sequencer and its output stage.
package sram_fifo_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_HOLD = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RUN  = 2'd2;

    localparam int unsigned RST_HOLD_DEF    = 5;
    localparam int unsigned RST_RECOVER_DEF = 4;

    // Usage spans macro words plus the in-flight read plus two output-stage entries.
    function automatic int unsigned usage_width(input int unsigned depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/sram_fifo_out_stage.sv
// Two-entry register FIFO behind the macro read port. A word arriving on
// push_i falls straight through to the head when the stage is empty.
module sram_fifo_out_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] slot_q [2];
    logic [1:0]            cnt_q, cnt_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  store, drop, wr_ptr, stored_any;

    assign stored_any = (cnt_q != 2'd0);
    assign valid_o    = stored_any | push_i;
    assign head_o     = stored_any ? slot_q[rd_ptr_q] : push_data_i;
    assign count_o    = cnt_q;

    // A push consumed in the same cycle by a pop of an empty stage never lands.
    assign drop   = pop_i & stored_any;
    assign store  = push_i & ~(pop_i & ~stored_any);
    assign wr_ptr = rd_ptr_q ^ cnt_q[0];

    always_comb begin
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            cnt_d    = 2'd0;
            rd_ptr_d = 1'b0;
        end else begin
            cnt_d = cnt_q + {1'b0, store} - {1'b0, drop};
            if (drop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store && !clr_i) begin
            slot_q[wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Reset/recovery sequencer and FWFT front end for the BRAM FIFO macro.
// RDEN/WREN are gated so the macro never sees an illegal access.
//
// state   | meaning
// --------+---------------------------------------------------
// ST_HOLD | macro RST asserted while the hold counter runs
// ST_WAIT | RST released, enables held off during recovery
// ST_RUN  | normal read/write traffic
module sram_fifo_ctrl
    import sram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned RST_HOLD    = RST_HOLD_DEF,
    parameter int unsigned RST_RECOVER = RST_RECOVER_DEF,
    parameter int unsigned USAGE_W     = usage_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  mac_rst_o,
    output logic                  mac_wren_o,
    output logic [DATA_WIDTH-1:0] mac_di_o,
    output logic                  mac_rden_o,
    input  logic [DATA_WIDTH-1:0] mac_do_i,
    input  logic                  mac_empty_i,
    input  logic                  mac_full_i,
    input  logic                  mac_rderr_i,
    input  logic                  mac_wrerr_i,
    output logic                  init_done_o,
    output logic [USAGE_W-1:0]    usage_o,
    output logic                  err_o
);

    localparam int unsigned CNT_MAX = (RST_HOLD > RST_RECOVER) ? RST_HOLD : RST_RECOVER;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   HOLD_LD = CNT_W'(RST_HOLD);
    localparam logic [CNT_W-1:0]   REC_LD  = CNT_W'(RST_RECOVER);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [USAGE_W-1:0] DEPTH_U = USAGE_W'(DEPTH);
    localparam logic [USAGE_W-1:0] ONE_U   = USAGE_W'(1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [USAGE_W-1:0]   mem_cnt_q, mem_cnt_d;
    logic                 inflight_q;
    logic                 err_q, err_d;
    logic                 run, pop, stage_valid;
    logic [1:0]           ob_cnt;
    logic [2:0]           occ;

    assign run         = (state_q == ST_RUN);
    assign init_done_o = run;
    assign mac_rst_o   = (state_q == ST_HOLD);
    assign err_o       = err_q;

    assign in_ready_o = run & ~flush_i & ~mac_full_i & (mem_cnt_q < DEPTH_U);
    assign mac_wren_o = in_valid_i & in_ready_o;
    assign mac_di_o   = in_data_i;

    assign out_valid_o = run & stage_valid;
    assign pop         = out_valid_o & out_ready_i;

    // Words already committed to the output side: stored entries plus the read in flight.
    assign occ        = {1'b0, ob_cnt} + {2'b00, inflight_q};
    assign mac_rden_o = run & ~flush_i & ~mac_empty_i & (mem_cnt_q != '0)
                      & (occ < (3'd2 + {2'b00, pop}));

    assign usage_o = mem_cnt_q + USAGE_W'(ob_cnt) + USAGE_W'(inflight_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_WAIT;
                        cnt_d   = REC_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end
            endcase
        end
    end

    always_comb begin
        mem_cnt_d = mem_cnt_q;
        err_d     = err_q;
        if (flush_i) begin
            mem_cnt_d = '0;
            err_d     = 1'b0;
        end else begin
            if (mac_wren_o && !mac_rden_o) begin
                mem_cnt_d = mem_cnt_q + ONE_U;
            end else if (!mac_wren_o && mac_rden_o) begin
                mem_cnt_d = mem_cnt_q - ONE_U;
            end
            if (run && (mac_rderr_i || mac_wrerr_i)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_HOLD;
            cnt_q      <= HOLD_LD;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= mac_rden_o;
            err_q      <= err_d;
        end
    end

    sram_fifo_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (flush_i),
        .push_i      (inflight_q),
        .push_data_i (mac_do_i),
        .pop_i       (pop),
        .valid_o     (stage_valid),
        .head_o      (out_data_o),
        .count_o     (ob_cnt)
    );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomized bench for sram_fifo_ctrl against a queue-based macro model,
// an occupancy-level controller model and an in-order data scoreboard.
module tb_sram_fifo_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 512;
    localparam int HOLD  = 5;
    localparam int REC   = 4;
    localparam int UW    = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data, mac_di, mac_do;
    logic          mac_rst, mac_wren, mac_rden, mac_empty, mac_full;
    logic          mac_rderr, mac_wrerr, init_done, err;
    logic [UW-1:0] usage;

    sram_fifo_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .mac_rst_o   (mac_rst),
        .mac_wren_o  (mac_wren),
        .mac_di_o    (mac_di),
        .mac_rden_o  (mac_rden),
        .mac_do_i    (mac_do),
        .mac_empty_i (mac_empty),
        .mac_full_i  (mac_full),
        .mac_rderr_i (mac_rderr),
        .mac_wrerr_i (mac_wrerr),
        .init_done_o (init_done),
        .usage_o     (usage),
        .err_o       (err)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Macro model: EMPTY/FULL follow the registered word count; stall adds extra EMPTY cycles.
    logic [DW-1:0] mq[$];
    int            mq_n  = 0;
    logic          stall = 1'b0;
    assign mac_empty = (mq_n == 0) || stall;
    assign mac_full  = (mq_n >= DEPTH);
    assign mac_wrerr = 1'b0;

    // Controller model: cycles since sequence start, macro words, words on the output side.
    int            k     = 0;
    int            mem_m = 0;
    int            vis_m = 0;
    bit            err_m = 1'b0;
    logic [DW-1:0] sb[$];

    bit ex_run, ex_rst, ex_ready, ex_wren, ex_valid, ex_pop, ex_rden;

    logic          s_rst, s_init, s_ready, s_wren, s_rden, s_valid, s_err;
    logic [DW-1:0] s_data, s_di;
    logic [UW-1:0] s_usage;

    task automatic fail(input string name, input string detail);
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
        if (errors > 300) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) fail(name, $sformatf("got %0h, want %0h", act, exp));
    endtask

    task automatic step();
        @(negedge clk);
        ex_run   = (k >= HOLD + REC);
        ex_rst   = (k < HOLD);
        ex_ready = ex_run && !flush && !mac_full && (mem_m < DEPTH);
        ex_wren  = in_valid && ex_ready;
        ex_valid = ex_run && (vis_m > 0);
        ex_pop   = ex_valid && out_ready;
        ex_rden  = ex_run && !flush && !mac_empty && (mem_m != 0) && (vis_m - int'(ex_pop) < 2);

        s_rst = mac_rst;   s_init = init_done; s_ready = in_ready; s_wren = mac_wren;
        s_rden = mac_rden; s_valid = out_valid; s_err = err;      s_data = out_data;
        s_di = mac_di;     s_usage = usage;

        chk("mac_rst", mac_rst, ex_rst);
        chk("init_done", init_done, ex_run);
        chk("in_ready", in_ready, ex_ready);
        chk("mac_wren", mac_wren, ex_wren);
        chk("mac_rden", mac_rden, ex_rden);
        chk("out_valid", out_valid, ex_valid);
        chk("usage", usage, mem_m + vis_m);
        chk("err", err, err_m);
        if (mac_wren) chk("mac_di", mac_di, in_data);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fail("stale_pop", $sformatf("got word %0h, want no word", out_data));
            end else begin
                chk("out_data", out_data, sb.pop_front());
            end
        end
        if (mac_wren) sb.push_back(in_data);

        @(posedge clk);
        #1;
        if (s_rst) begin
            mq.delete();
        end else begin
            if (s_rden) begin
                checks++;
                if (mq.size() == 0) fail("mac_rderr", "read issued to an empty macro, want none");
                else mac_do = mq.pop_front();
            end
            if (s_wren) begin
                checks++;
                if (mq.size() >= DEPTH) fail("mac_wrerr", "write issued to a full macro, want none");
                else mq.push_back(s_di);
            end
        end
        mq_n = mq.size();

        if (!rst_n || flush) begin
            k = 0; mem_m = 0; vis_m = 0; err_m = 1'b0;
            sb.delete();
        end else begin
            if (ex_run && (mac_rderr || mac_wrerr)) err_m = 1'b1;
            mem_m += int'(ex_wren) - int'(ex_rden);
            vis_m += int'(ex_rden) - int'(ex_pop);
            if (k < 1000) k++;
        end
        cyc++;
    endtask

    task automatic drain();
        int c;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while (usage != '0 && c < 2000) begin
            step();
            c++;
        end
        chk("drain_bound", c < 2000, 1'b1);
    endtask

    initial begin
        int            acc, pops, c;
        bit            seen;
        logic [DW-1:0] next_w, last;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; mac_do = 32'hDEAD_BEEF; mac_rderr = 1'b0;

        // Reset and release sequence
        repeat (3) step();
        chk("rst_mac_rst", s_rst, 1'b1);
        chk("rst_usage", s_usage, 0);
        chk("rst_ready", s_ready, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 4) chk("rel_rst_c4", s_rst, 1'b1);
            if (i == 5) chk("rel_rst_c5", s_rst, 1'b0);
            if (i == 8) chk("rel_ready_c8", s_ready, 1'b0);
            if (i == 9) begin
                chk("rel_init_c9", s_init, 1'b1);
                chk("rel_ready_c9", s_ready, 1'b1);
            end
        end

        // Single word through an empty FIFO
        in_valid = 1'b1; in_data = 32'hA5A5_0001;
        step();
        chk("single_wren", s_wren, 1'b1);
        in_valid = 1'b0;
        step();
        chk("single_rden", s_rden, 1'b1);
        chk("single_usage1", s_usage, 1);
        chk("single_valid_early", s_valid, 1'b0);
        step();
        chk("single_valid", s_valid, 1'b1);
        chk("single_data", s_data, 32'hA5A5_0001);
        chk("single_usage2", s_usage, 1);
        step();
        chk("single_usage3", s_usage, 1);
        drain();

        // Random-gap stream of 1000 incrementing words
        next_w = 32'h1000_0000; acc = 0; pops = 0; c = 0; last = '0;
        out_ready = 1'b1;
        while ((acc < 1000 || usage != '0) && c < 20000) begin
            in_valid = (acc < 1000) && ($urandom_range(0, 3) != 0);
            in_data  = next_w;
            stall    = ($urandom_range(0, 7) == 0);
            step();
            if (s_wren) begin acc++; next_w++; end
            if (s_valid) begin pops++; last = s_data; end
            c++;
        end
        stall = 1'b0; in_valid = 1'b0;
        chk("stream_bound", c < 20000, 1'b1);
        chk("stream_pops", pops, 1000);
        chk("stream_last", last, 32'h1000_03E7);

        // Back-to-back traffic sustains one word per cycle
        in_valid = 1'b1; out_ready = 1'b1; pops = 0;
        for (int i = 0; i < 120; i++) begin
            in_data = next_w;
            step();
            if (s_wren) next_w++;
            if (i >= 10 && s_valid) pops++;
        end
        chk("throughput", pops, 110);
        drain();

        // Fill to capacity with the consumer stalled
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 540; i++) begin
            in_data = next_w;
            step();
            if (s_wren) next_w++;
        end
        chk("full_ready", s_ready, 1'b0);
        chk("full_usage", s_usage, 514);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data = next_w;
            step();
            if (s_wren) next_w++;
            if (s_ready) seen = 1'b1;
        end
        chk("full_reopen", seen, 1'b1);
        drain();

        // Flush with words stored and a read in flight
        out_ready = 1'b0; acc = 0; c = 0;
        while (acc < 40 && c < 200) begin
            in_valid = 1'b1; in_data = next_w;
            step();
            if (s_wren) begin acc++; next_w++; end
            c++;
        end
        in_valid = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        mac_do = 32'hBAD0_BAD0;
        step();
        chk("flush_hold", s_rst, 1'b1);
        chk("flush_usage", s_usage, 0);
        for (int i = 0; i < 14; i++) begin
            step();
            chk("flush_no_stale", s_valid, 1'b0);
        end
        in_valid = 1'b1; in_data = 32'h5555_0001;
        step();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_valid && !seen) begin
                seen = 1'b1;
                chk("flush_new_data", s_data, 32'h5555_0001);
            end
        end
        chk("flush_new_seen", seen, 1'b1);

        // Sticky error flag
        mac_rderr = 1'b1;
        step();
        mac_rderr = 1'b0;
        step();
        chk("err_set", s_err, 1'b1);
        repeat (5) step();
        chk("err_sticky", s_err, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("err_cleared", s_err, 1'b0);
        repeat (12) step();
        chk("err_rerun", s_init, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
